// File: rtl/aes_round_ctrl_if.sv
// Host-side request/response handshake of the AES-128 round sequencer.
// The host drives the master side and the controller implements the slave side.
interface aes_round_ctrl_if;
    logic start_valid;
    logic start_ready;
    logic done_valid;
    logic done_ready;
    logic abort;

    modport master (
        output start_valid,
        output done_ready,
        output abort,
        input  start_ready,
        input  done_valid
    );

    modport slave (
        input  start_valid,
        input  done_ready,
        input  abort,
        output start_ready,
        output done_valid
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer: initial AddRoundKey, NROUNDS rounds, result hold.
// Produces round index and Rcon in lock-step with the round pulses.
module aes_round_ctrl #(
    parameter int NROUNDS      = 10,
    parameter int ROUND_CYCLES = 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    aes_round_ctrl_if.slave  host,
    output logic             ld_init,
    output logic             round_en,
    output logic             key_step,
    output logic             mix_en,
    output logic [7:0]       rcon,
    output logic [3:0]       round_idx,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, INIT, ROUND, DONE} state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NROUNDS);
    localparam logic [2:0] LAST_SUB   = 3'(ROUND_CYCLES - 1);

    state_t      state_reg;
    logic [3:0]  round_idx_reg;
    logic [2:0]  sub_cnt_reg;
    logic [7:0]  rcon_reg;
    logic        ld_init_reg;
    logic        round_en_reg;
    logic        mix_en_reg;
    logic        done_valid_reg;
    logic        busy_reg;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Every output register is loaded with the decode of the state being entered,
    // so outputs change only at the clock edge together with the state.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || host.abort) begin
            state_reg      <= IDLE;
            round_idx_reg  <= 4'd0;
            sub_cnt_reg    <= 3'd0;
            rcon_reg       <= 8'h00;
            ld_init_reg    <= 1'b0;
            round_en_reg   <= 1'b0;
            mix_en_reg     <= 1'b0;
            done_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            ld_init_reg  <= 1'b0;
            round_en_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (host.start_valid) begin
                        state_reg     <= INIT;
                        ld_init_reg   <= 1'b1;
                        busy_reg      <= 1'b1;
                        round_idx_reg <= 4'd0;
                        rcon_reg      <= 8'h00;
                    end
                end
                INIT: begin
                    state_reg     <= ROUND;
                    round_idx_reg <= 4'd1;
                    sub_cnt_reg   <= 3'd0;
                    rcon_reg      <= 8'h01;
                    mix_en_reg    <= (LAST_ROUND != 4'd1);
                    round_en_reg  <= (LAST_SUB == 3'd0);
                end
                ROUND: begin
                    if (sub_cnt_reg == LAST_SUB) begin
                        sub_cnt_reg <= 3'd0;
                        if (round_idx_reg == LAST_ROUND) begin
                            state_reg      <= DONE;
                            round_idx_reg  <= 4'd0;
                            rcon_reg       <= 8'h00;
                            mix_en_reg     <= 1'b0;
                            busy_reg       <= 1'b0;
                            done_valid_reg <= 1'b1;
                        end else begin
                            round_idx_reg <= round_idx_reg + 4'd1;
                            rcon_reg      <= xtime(rcon_reg);
                            mix_en_reg    <= ((round_idx_reg + 4'd1) != LAST_ROUND);
                            round_en_reg  <= (LAST_SUB == 3'd0);
                        end
                    end else begin
                        sub_cnt_reg  <= sub_cnt_reg + 3'd1;
                        round_en_reg <= ((sub_cnt_reg + 3'd1) == LAST_SUB);
                    end
                end
                DONE: begin
                    // start_valid is not looked at here, so no job can overlap the hold phase
                    if (host.done_ready) begin
                        state_reg      <= IDLE;
                        done_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign host.start_ready = (state_reg == IDLE) && !host.abort;
    assign host.done_valid  = done_valid_reg;
    assign ld_init          = ld_init_reg;
    assign round_en         = round_en_reg;
    assign key_step         = round_en_reg;
    assign mix_en           = mix_en_reg;
    assign rcon             = rcon_reg;
    assign round_idx        = round_idx_reg;
    assign busy             = busy_reg;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: cycle-exact output checks for two configurations
// plus an AES-128 datapath model driven by the controller for the FIPS-197 vector.
module tb_aes_round_ctrl;

    logic sys_clk;
    logic sys_rst;

    aes_round_ctrl_if hif ();
    aes_round_ctrl_if hif3 ();

    logic       ld_init, round_en, key_step, mix_en, busy;
    logic [7:0] rcon;
    logic [3:0] round_idx;
    logic       ld_init3, round_en3, key_step3, mix_en3, busy3;
    logic [7:0] rcon3;
    logic [3:0] round_idx3;

    aes_round_ctrl dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .host      (hif.slave),
        .ld_init   (ld_init),
        .round_en  (round_en),
        .key_step  (key_step),
        .mix_en    (mix_en),
        .rcon      (rcon),
        .round_idx (round_idx),
        .busy      (busy)
    );

    aes_round_ctrl #(.NROUNDS(10), .ROUND_CYCLES(3)) dut3 (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .host      (hif3.slave),
        .ld_init   (ld_init3),
        .round_en  (round_en3),
        .key_step  (key_step3),
        .mix_en    (mix_en3),
        .rcon      (rcon3),
        .round_idx (round_idx3),
        .busy      (busy3)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    localparam logic [18:0]  IDLE_VEC = 19'h01000;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    // ---------------- AES-128 reference datapath ----------------
    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box from its definition: GF(2^8) inverse (a^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h01;
        if (a == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] s, input int i);
        return s[127 - 8*i -: 8];
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(4*c + r) -: 8] = sbox(gb(s, 4*((c + r) % 4) + r));
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = gb(s, 4*c); a1 = gb(s, 4*c + 1); a2 = gb(s, 4*c + 2); a3 = gb(s, 4*c + 3);
            o[127 - 8*(4*c)     -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[127 - 8*(4*c + 1) -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[127 - 8*(4*c + 2) -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[127 - 8*(4*c + 3) -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    logic [127:0] ptext, key, m_state, m_key, nk, ns;

    always @(posedge sys_clk) begin
        if (ld_init) begin
            m_state <= ptext ^ key;
            m_key   <= key;
        end else if (round_en) begin
            nk = key_next(m_key, rcon);
            ns = sub_shift(m_state);
            if (mix_en) ns = mix_cols(ns);
            m_state <= ns ^ nk;
            m_key   <= nk;
        end
    end

    // ---------------- expected controller outputs ----------------
    // Packing: {ld_init, round_en, key_step, mix_en, done_valid, busy, start_ready, round_idx, rcon}
    function automatic logic [18:0] exp_out(input int c, input int rc);
        logic       ld, inr, ren, mix, dv, bz, sr;
        logic [3:0] r;
        logic [7:0] rv;
        ld  = (c == 1);
        inr = (c >= 2) && (c <= 1 + 10*rc);
        r   = inr ? 4'((c - 2) / rc + 1) : 4'd0;
        ren = inr && (((c - 1) % rc) == 0);
        mix = inr && (r != 4'd10);
        dv  = (c == 2 + 10*rc);
        bz  = (c >= 1) && (c <= 1 + 10*rc);
        sr  = (c == 3 + 10*rc);
        rv  = inr ? rcon_tab[(c - 2) / rc] : 8'h00;
        return {ld, ren, ren, mix, dv, bz, sr, r, rv};
    endfunction

    function automatic logic [18:0] obs_d();
        return {ld_init, round_en, key_step, mix_en, hif.done_valid, busy, hif.start_ready, round_idx, rcon};
    endfunction

    function automatic logic [18:0] obs_3();
        return {ld_init3, round_en3, key_step3, mix_en3, hif3.done_valid, busy3, hif3.start_ready, round_idx3, rcon3};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge sys_clk);
        #1;
    endtask

    // Default-config job from acceptance through return to IDLE, done_ready held high
    task automatic run_default(input string tag);
        hif.done_ready  = 1'b1;
        hif.start_valid = 1'b1;
        @(negedge sys_clk);
        hif.start_valid = 1'b0;
        #1;
        check($sformatf("%s c1", tag), 128'(obs_d()), 128'(exp_out(1, 1)));
        for (int c = 2; c <= 13; c++) begin
            step();
            check($sformatf("%s c%0d", tag, c), 128'(obs_d()), 128'(exp_out(c, 1)));
            if (c == 12) check($sformatf("%s ctext", tag), m_state, FIPS_CT);
        end
        $display("job %s: ctext=%h", tag, m_state);
    endtask

    int dv_seen;

    initial begin
        ptext = FIPS_PT;
        key   = FIPS_KEY;
        sys_rst          = 1'b1;
        hif.start_valid  = 1'b0;
        hif.done_ready   = 1'b0;
        hif.abort        = 1'b0;
        hif3.start_valid = 1'b0;
        hif3.done_ready  = 1'b1;
        hif3.abort       = 1'b0;

        // Reset state
        step();
        step();
        sys_rst = 1'b0;
        #1;
        check("reset dflt", 128'(obs_d()), 128'(IDLE_VEC));
        check("reset rc3", 128'(obs_3()), 128'(IDLE_VEC));
        $display("txn reset: outputs idle");

        // Default job with FIPS-197 vector
        run_default("job1");

        // ROUND_CYCLES=3 job
        hif3.start_valid = 1'b1;
        @(negedge sys_clk);
        hif3.start_valid = 1'b0;
        #1;
        check("rc3 c1", 128'(obs_3()), 128'(exp_out(1, 3)));
        for (int c = 2; c <= 33; c++) begin
            step();
            check($sformatf("rc3 c%0d", c), 128'(obs_3()), 128'(exp_out(c, 3)));
        end
        $display("txn rc3 job: 10 rounds of 3 cycles");

        // Backpressure: done_ready low for 5 cycles, start_valid pending meanwhile
        hif.done_ready  = 1'b0;
        hif.start_valid = 1'b1;
        @(negedge sys_clk);
        hif.start_valid = 1'b0;
        #1;
        for (int c = 1; c <= 11; c++) begin
            if (c > 1) step();
            check($sformatf("bp c%0d", c), 128'(obs_d()), 128'(exp_out(c, 1)));
        end
        for (int c = 12; c <= 17; c++) begin
            @(negedge sys_clk);
            hif.start_valid = 1'b1;
            hif.done_ready  = (c == 17);
            #1;
            check($sformatf("bp hold c%0d", c), 128'({hif.done_valid, hif.start_ready, ld_init}), 128'(3'b100));
        end
        check("bp ctext", m_state, FIPS_CT);
        step();
        check("bp idle c18", 128'(obs_d()), 128'(IDLE_VEC));
        @(negedge sys_clk);
        hif.start_valid = 1'b0;
        #1;
        check("job2 c1", 128'(obs_d()), 128'(exp_out(1, 1)));
        for (int c = 2; c <= 13; c++) begin
            step();
            check($sformatf("job2 c%0d", c), 128'(obs_d()), 128'(exp_out(c, 1)));
            if (c == 12) check("job2 ctext", m_state, FIPS_CT);
        end
        $display("txn backpressure + job2: ctext=%h", m_state);

        // Abort at cycle 6
        hif.start_valid = 1'b1;
        @(negedge sys_clk);
        hif.start_valid = 1'b0;
        #1;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) step();
            check($sformatf("ab c%0d", c), 128'(obs_d()), 128'(exp_out(c, 1)));
        end
        @(negedge sys_clk);
        hif.abort = 1'b1;
        #1;
        check("ab c6", 128'(obs_d()), 128'(exp_out(6, 1)));
        @(negedge sys_clk);
        hif.abort = 1'b0;
        #1;
        check("ab c7 idle", 128'(obs_d()), 128'(IDLE_VEC));
        dv_seen = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (hif.done_valid) dv_seen++;
        end
        check("ab no done", 128'(dv_seen), 128'(0));
        $display("txn abort: job cancelled at cycle 6");
        run_default("after_abort");

        // Reset mid-job
        hif.start_valid = 1'b1;
        @(negedge sys_clk);
        hif.start_valid = 1'b0;
        #1;
        for (int c = 2; c <= 3; c++) step();
        check("rst c3", 128'(obs_d()), 128'(exp_out(3, 1)));
        @(negedge sys_clk);
        sys_rst = 1'b1;
        #1;
        check("rst c4", 128'(obs_d()), 128'(exp_out(4, 1)));
        @(negedge sys_clk);
        sys_rst = 1'b0;
        #1;
        check("rst c5 idle", 128'(obs_d()), 128'(IDLE_VEC));
        $display("txn reset mid-job: back to idle");

        // abort together with start_valid in IDLE
        @(negedge sys_clk);
        hif.abort       = 1'b1;
        hif.start_valid = 1'b1;
        #1;
        check("abst ready", 128'(hif.start_ready), 128'(1'b0));
        @(negedge sys_clk);
        hif.abort       = 1'b0;
        hif.start_valid = 1'b0;
        #1;
        check("abst no ld", 128'(obs_d()), 128'(IDLE_VEC));
        step();
        check("abst still idle", 128'(obs_d()), 128'(IDLE_VEC));
        $display("txn abort+start in idle: not accepted");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Iterative round sequencer for the AES-128 encryption datapath. It accepts a start request, drives the datapath through the initial AddRoundKey, NROUNDS full rounds (MixColumns suppressed in the last one) and a result-hold phase. It generates the round index and the key-schedule round constant (Rcon) in lock-step. It sits between the host-side request/response handshake and the combinational round logic / key-expansion registers of the encryption core.

## Interface
Parameters:
- NROUNDS, 10, number of cipher rounds after the initial AddRoundKey; legal range 1..14.
- ROUND_CYCLES, 1, clock cycles spent per round (datapath S-box latency); legal range 1..8.

Ports:
- sys_clk  in  1  single system clock; all logic on rising edge.
- sys_rst  in  1  reset, synchronous, active-high; highest priority.
- start_valid  in  1  host requests an encryption (ptext/key already stable on datapath inputs).
- start_ready  out  1  controller can accept; `(state==IDLE) & ~abort`.
- done_valid  out  1  ciphertext valid on datapath outputs.
- done_ready  in  1  host consumes result.
- abort  in  1  synchronous cancel; returns to IDLE.
- ld_init  out  1  one-cycle pulse: datapath loads ptext^key into state reg, key into key reg.
- round_en  out  1  one-cycle pulse: datapath registers round result.
- key_step  out  1  one-cycle pulse: key schedule advances using rcon; always equal to round_en.
- mix_en  out  1  MixColumns enable for the current round.
- rcon  out  8  round constant for the current round.
- round_idx  out  4  current round number.
- busy  out  1  high in INIT and ROUND.

## Operation
- FSM states: IDLE, INIT, ROUND, DONE.
- Internal counters: round_idx (4 b) and sub_cnt (3 b).
- IDLE:
  - start_ready=1 unless abort.
  - start_valid&start_ready → INIT.
- INIT (1 cycle):
  - ld_init=1, round_idx=0, rcon=0.
  - Next state ROUND with round_idx=1, sub_cnt=0, rcon=0x01.
- ROUND:
  - sub_cnt counts 0..ROUND_CYCLES-1.
  - round_en=key_step=1 only when sub_cnt==ROUND_CYCLES-1.
  - mix_en=(round_idx!=NROUNDS), held for the whole round.
  - At the round_en cycle:
    - If round_idx==NROUNDS → DONE.
    - Otherwise round_idx+1, sub_cnt=0, rcon=xtime(rcon), where xtime(x) = {x[6:0],0} ^ (x[7] ? 0x1B : 0x00).
  - Rcon sequence: 01,02,04,08,10,20,40,80,1B,36,6C,D8,AB,4D.
- DONE:
  - done_valid=1, held until done_ready sampled high; then IDLE.
  - start_ready=0 in DONE. No overlap of jobs.
- Outputs outside their state:
  - ld_init, round_en, key_step, mix_en and done_valid are 0.
  - rcon=0 and round_idx=0 in IDLE, INIT and DONE.
- abort:
  - In any state, the next state is IDLE and all pulses are 0 in that cycle.
  - No done_valid is produced for the aborted job.
  - abort in DONE discards the result.
- sys_rst: next state IDLE, counters 0; overrides abort and start.

## Timing
- Reset: in the cycle after sys_rst is sampled high, start_ready=1 (if abort=0) and every other output is 0, with round_idx=0 and rcon=0x00.
- Cycle numbering: cycle 1 is the first cycle after the edge that accepts start.
  - ld_init in cycle 1.
  - round_en for round r (1..NROUNDS) in cycle 1+r·ROUND_CYCLES.
  - done_valid from cycle 2+NROUNDS·ROUND_CYCLES.
  - Defaults give ld_init in cycle 1, round_en in cycles 2..11, done_valid from cycle 12.
- Return to IDLE:
  - done_ready high on the first done_valid cycle: IDLE next cycle, so the earliest next acceptance is 1 cycle after completion.
  - start_valid in the same cycle as done_ready is not accepted; it is accepted the following cycle if still high.
- Output behaviour: all outputs are registered state decodes except start_ready, which is combinational with abort. No output glitches are permitted across state boundaries.
- Simultaneous events:
  - abort with start_valid in IDLE: not accepted.
  - abort on a round_en cycle: round_en still asserted (it is a state decode), next state IDLE.
  - sys_rst mid-ROUND: IDLE next cycle, rcon=0.

## Test plan
- Default params, single job, done_ready tied 1:
  - ld_init at cycle 1.
  - round_en at cycles 2..11, with rcon 01,02,04,08,10,20,40,80,1B,36 and round_idx 1..10.
  - mix_en=0 only at round 10.
  - done_valid for exactly cycle 12; start_ready again at cycle 13.
- ROUND_CYCLES=3:
  - round_en at cycles 4,7,…,31; done_valid at cycle 32.
  - rcon/round_idx stable across each 3-cycle round.
- Backpressure:
  - done_ready low 5 cycles: done_valid held 6 cycles, start_valid ignored meanwhile.
  - Job 2 accepted the cycle after the handshake, rcon restarts at 01.
- abort:
  - Asserted at cycle 6 of a default job: IDLE at cycle 7, no done_valid.
  - Next job runs normally.
- Reset and priority:
  - sys_rst pulsed at cycle 4: all outputs 0, start_ready=1 next cycle.
  - abort with start_valid in IDLE: no ld_init follows.
- Hook the controller to the AES datapath and run the FIPS-197 vector:
  - key 000102…0F, ptext 00112233…FF → ctext 69C4E0D8 6A7B0430 D8CDB780 70B4C55A.
  - done_valid at cycle 12.
